// File: rtl/commit_unit.sv
// In-order retirement stage: pops the ROB head, writes the register file, commits stores,
// updates the branch predictor and raises a flush/redirect with a programmable drain window.
module commit_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        doute_valid,
    input  logic        doute_ready,
    input  logic [31:0] doute_pc,
    input  logic [3:0]  doute_rob,
    input  logic [4:0]  doute_dst,
    input  logic [31:0] doute_value,
    input  logic [7:0]  doute_fid,
    input  logic        doute_load,
    input  logic        doute_store,
    input  logic        doute_lsmiss,
    input  logic [1:0]  doute_lswidth,
    input  logic [3:0]  doute_cmtdelay,
    input  logic        doute_bco_valid,
    input  logic        doute_bco_taken,
    input  logic [1:0]  doute_bco_pattern,
    input  logic [31:0] doute_bco_target,
    output logic        en_commit,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        sb_commit_valid,
    input  logic        sb_commit_ready,
    output logic [7:0]  sb_commit_fid,
    output logic [1:0]  sb_commit_width,
    output logic        bco_valid,
    output logic [31:0] redirect_pc,
    output logic        bp_update_valid,
    output logic        bp_update_taken,
    output logic [31:0] bp_update_pc,
    output logic [31:0] bp_update_target,
    output logic [1:0]  bp_update_pattern,
    output logic [31:0] retire_count
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] flush_cnt, flush_cnt_nxt;
    logic       head;
    logic       counted;
    logic       rf_wr;
    logic       bp_wr;
    logic       unused;

    assign head   = doute_valid & doute_ready;
    assign unused = ^{doute_rob, doute_cmtdelay, doute_load};

    assign sb_commit_fid   = doute_fid;
    assign sb_commit_width = doute_lswidth;

    always_comb begin
        state_nxt       = state;
        flush_cnt_nxt   = flush_cnt;
        en_commit       = 1'b0;
        sb_commit_valid = 1'b0;
        case (state)
            RUN: begin
                sb_commit_valid = head & doute_store & ~doute_lsmiss;
                en_commit       = head & (~doute_store | doute_lsmiss | sb_commit_ready);
                if (en_commit && (doute_lsmiss || doute_bco_valid)) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (flush_cnt == 4'd0) begin
                    state_nxt = RUN;
                end else begin
                    flush_cnt_nxt = flush_cnt - 4'd1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // A miss replays without retiring; a branch override retires (and writes even if it is a store).
    assign counted = en_commit & ~doute_lsmiss;
    assign bp_wr   = counted & doute_bco_valid;
    assign rf_wr   = counted & (doute_bco_valid | ~doute_store) & (doute_dst != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we             <= 1'b0;
            rf_waddr          <= '0;
            rf_wdata          <= '0;
            bco_valid         <= 1'b0;
            redirect_pc       <= '0;
            bp_update_valid   <= 1'b0;
            bp_update_taken   <= 1'b0;
            bp_update_pc      <= '0;
            bp_update_target  <= '0;
            bp_update_pattern <= '0;
            retire_count      <= '0;
        end else begin
            rf_we           <= rf_wr;
            bp_update_valid <= bp_wr;
            bco_valid       <= 1'b0;
            if (rf_wr) begin
                rf_waddr <= doute_dst;
                rf_wdata <= doute_value;
            end
            if (en_commit && doute_lsmiss) begin
                bco_valid   <= 1'b1;
                redirect_pc <= doute_pc;
            end else if (bp_wr) begin
                bco_valid   <= 1'b1;
                redirect_pc <= doute_bco_target;
            end
            if (bp_wr) begin
                bp_update_taken   <= doute_bco_taken;
                bp_update_pc      <= doute_pc;
                bp_update_target  <= doute_bco_target;
                bp_update_pattern <= doute_bco_pattern;
            end
            if (counted) begin
                retire_count <= retire_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit with a scoreboard of expected RF writes, redirects,
// predictor updates and store commits, checked as the DUT produces them.
module tb_commit_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        doute_valid, doute_ready;
    logic [31:0] doute_pc;
    logic [3:0]  doute_rob;
    logic [4:0]  doute_dst;
    logic [31:0] doute_value;
    logic [7:0]  doute_fid;
    logic        doute_load, doute_store, doute_lsmiss;
    logic [1:0]  doute_lswidth;
    logic [3:0]  doute_cmtdelay;
    logic        doute_bco_valid, doute_bco_taken;
    logic [1:0]  doute_bco_pattern;
    logic [31:0] doute_bco_target;
    logic        en_commit, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        sb_commit_valid, sb_commit_ready;
    logic [7:0]  sb_commit_fid;
    logic [1:0]  sb_commit_width;
    logic        bco_valid;
    logic [31:0] redirect_pc;
    logic        bp_update_valid, bp_update_taken;
    logic [31:0] bp_update_pc, bp_update_target;
    logic [1:0]  bp_update_pattern;
    logic [31:0] retire_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [36:0] rf_q[$];
    logic [31:0] redir_q[$];
    logic [66:0] bp_q[$];
    logic [9:0]  sb_q[$];

    always #5 clk = ~clk;

    commit_unit #(.FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .doute_valid(doute_valid), .doute_ready(doute_ready),
        .doute_pc(doute_pc), .doute_rob(doute_rob), .doute_dst(doute_dst),
        .doute_value(doute_value), .doute_fid(doute_fid),
        .doute_load(doute_load), .doute_store(doute_store), .doute_lsmiss(doute_lsmiss),
        .doute_lswidth(doute_lswidth), .doute_cmtdelay(doute_cmtdelay),
        .doute_bco_valid(doute_bco_valid), .doute_bco_taken(doute_bco_taken),
        .doute_bco_pattern(doute_bco_pattern), .doute_bco_target(doute_bco_target),
        .en_commit(en_commit), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sb_commit_valid(sb_commit_valid), .sb_commit_ready(sb_commit_ready),
        .sb_commit_fid(sb_commit_fid), .sb_commit_width(sb_commit_width),
        .bco_valid(bco_valid), .redirect_pc(redirect_pc),
        .bp_update_valid(bp_update_valid), .bp_update_taken(bp_update_taken),
        .bp_update_pc(bp_update_pc), .bp_update_target(bp_update_target),
        .bp_update_pattern(bp_update_pattern), .retire_count(retire_count)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        doute_valid       = 1'b0;
        doute_ready       = 1'b0;
        doute_pc          = '0;
        doute_rob         = '0;
        doute_dst         = '0;
        doute_value       = '0;
        doute_fid         = '0;
        doute_load        = 1'b0;
        doute_store       = 1'b0;
        doute_lsmiss      = 1'b0;
        doute_lswidth     = '0;
        doute_cmtdelay    = '0;
        doute_bco_valid   = 1'b0;
        doute_bco_taken   = 1'b0;
        doute_bco_pattern = '0;
        doute_bco_target  = '0;
        sb_commit_ready   = 1'b0;
    endtask

    task automatic alu(input logic [4:0] dst, input logic [31:0] val);
        idle();
        doute_valid = 1'b1;
        doute_ready = 1'b1;
        doute_pc    = 32'h0040_0000;
        doute_dst   = dst;
        doute_value = val;
    endtask

    // Scoreboard side: every registered pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (rf_we) begin
                if (rf_q.size() == 0) chk("rf_unexpected", {rf_waddr, rf_wdata}, 37'h0);
                else chk("rf_write", {rf_waddr, rf_wdata}, rf_q.pop_front());
            end
            if (bco_valid) begin
                if (redir_q.size() == 0) chk("redirect_unexpected", {1'b1, redirect_pc}, 33'h0);
                else chk("redirect_pc", redirect_pc, redir_q.pop_front());
            end
            if (bp_update_valid) begin
                if (bp_q.size() == 0)
                    chk("bp_unexpected", {1'b1, bp_update_pc}, 33'h0);
                else
                    chk("bp_update", {bp_update_pc, bp_update_target, bp_update_taken, bp_update_pattern},
                        bp_q.pop_front());
            end
            if (en_commit && sb_commit_valid) begin
                if (sb_q.size() == 0) chk("sb_unexpected", {1'b1, sb_commit_fid}, 9'h0);
                else chk("sb_commit", {sb_commit_fid, sb_commit_width}, sb_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (doute_valid) begin
            assert (doute_cmtdelay == 4'd0) else begin
                errors++;
                $error("FAIL cmtdelay observed=%0h expected=0", doute_cmtdelay);
            end
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        chk("reset_rf_we", rf_we, 1'b0);
        chk("reset_bco_valid", bco_valid, 1'b0);
        chk("reset_redirect", redirect_pc, 32'h0);
        chk("reset_bp_valid", bp_update_valid, 1'b0);
        chk("reset_retire", retire_count, 32'h0);
        chk("reset_en_commit", en_commit, 1'b0);
        chk("reset_sb_valid", sb_commit_valid, 1'b0);
        reset = 1'b0;
        step();

        // ALU retire x3
        for (int i = 0; i < 3; i++) begin
            alu(5'd5, 32'h1234_5678);
            rf_q.push_back({5'd5, 32'h1234_5678});
            #1;
            chk("alu_en_commit", en_commit, 1'b1);
            step();
        end
        idle();
        #1;
        chk("alu_retire_count", retire_count, 32'd3);
        step();

        // Store backpressure: four stalled cycles then acceptance
        for (int i = 0; i < 5; i++) begin
            idle();
            doute_valid   = 1'b1;
            doute_ready   = 1'b1;
            doute_store   = 1'b1;
            doute_fid     = 8'h5A;
            doute_lswidth = 2'd2;
            doute_dst     = 5'd6;
            sb_commit_ready = (i == 4);
            if (i == 4) sb_q.push_back({8'h5A, 2'd2});
            #1;
            chk("st_sb_valid", sb_commit_valid, 1'b1);
            chk("st_en_commit", en_commit, (i == 4));
            step();
        end
        idle();
        #1;
        chk("st_retire_count", retire_count, 32'd4);
        step();

        // Branch override with a 2-cycle drain
        idle();
        doute_valid       = 1'b1;
        doute_ready       = 1'b1;
        doute_pc          = 32'h0040_0010;
        doute_dst         = 5'd7;
        doute_value       = 32'h0000_CAFE;
        doute_bco_valid   = 1'b1;
        doute_bco_taken   = 1'b1;
        doute_bco_pattern = 2'b10;
        doute_bco_target  = 32'hBFC0_0100;
        rf_q.push_back({5'd7, 32'h0000_CAFE});
        redir_q.push_back(32'hBFC0_0100);
        bp_q.push_back({32'h0040_0010, 32'hBFC0_0100, 1'b1, 2'b10});
        #1;
        chk("br_en_commit", en_commit, 1'b1);
        step();
        alu(5'd0, 32'h1111_1111);
        #1;
        chk("br_t1_en_commit", en_commit, 1'b0);
        chk("br_t1_bco_valid", bco_valid, 1'b1);
        chk("br_t1_redirect", redirect_pc, 32'hBFC0_0100);
        chk("br_t1_bp_valid", bp_update_valid, 1'b1);
        step();
        chk("br_t2_en_commit", en_commit, 1'b0);
        chk("br_t2_bco_valid", bco_valid, 1'b0);
        step();
        chk("br_t3_en_commit", en_commit, 1'b1);
        step();
        idle();
        #1;
        chk("br_retire_count", retire_count, 32'd6);
        chk("dst0_no_rf_we", rf_we, 1'b0);

        // Load miss replays
        idle();
        doute_valid  = 1'b1;
        doute_ready  = 1'b1;
        doute_load   = 1'b1;
        doute_lsmiss = 1'b1;
        doute_pc     = 32'h8000_0040;
        doute_dst    = 5'd3;
        doute_value  = 32'h5555_AAAA;
        redir_q.push_back(32'h8000_0040);
        #1;
        chk("miss_en_commit", en_commit, 1'b1);
        step();
        idle();
        #1;
        chk("miss_retire_count", retire_count, 32'd6);
        chk("miss_rf_we", rf_we, 1'b0);
        chk("miss_bco_valid", bco_valid, 1'b1);
        step();
        step();

        // lsmiss beats bco_valid and store; no predictor update, no store commit
        idle();
        doute_valid      = 1'b1;
        doute_ready      = 1'b1;
        doute_store      = 1'b1;
        doute_lsmiss     = 1'b1;
        doute_bco_valid  = 1'b1;
        doute_pc         = 32'h1111_0000;
        doute_bco_target = 32'h2222_0000;
        redir_q.push_back(32'h1111_0000);
        #1;
        chk("prio_en_commit", en_commit, 1'b1);
        chk("prio_sb_valid", sb_commit_valid, 1'b0);
        step();
        idle();
        #1;
        chk("prio_bp_valid", bp_update_valid, 1'b0);
        chk("prio_retire_count", retire_count, 32'd6);
        step();
        step();

        // Stall: valid without ready has no effect
        alu(5'd4, 32'h4444_4444);
        doute_ready = 1'b0;
        #1;
        chk("stall_en_commit", en_commit, 1'b0);
        step();
        chk("stall_rf_we", rf_we, 1'b0);
        chk("stall_retire_count", retire_count, 32'd6);
        idle();
        step();

        // Reset during FLUSH
        idle();
        doute_valid      = 1'b1;
        doute_ready      = 1'b1;
        doute_bco_valid  = 1'b1;
        doute_pc         = 32'h0040_0100;
        doute_bco_target = 32'h3333_0000;
        #1;
        chk("rst_br_en_commit", en_commit, 1'b1);
        step();
        idle();
        reset = 1'b1;
        #1;
        chk("rst_bco_valid", bco_valid, 1'b0);
        chk("rst_redirect", redirect_pc, 32'h0);
        chk("rst_bp_valid", bp_update_valid, 1'b0);
        chk("rst_retire", retire_count, 32'h0);
        chk("rst_rf_we", rf_we, 1'b0);
        step();
        reset = 1'b0;
        alu(5'd9, 32'hDEAD_BEEF);
        rf_q.push_back({5'd9, 32'hDEAD_BEEF});
        #1;
        chk("rst_resume_en_commit", en_commit, 1'b1);
        step();
        idle();
        #1;
        chk("rst_resume_retire", retire_count, 32'd1);
        step();
        step();

        // retire_count wraps
        force dut.retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count;
        #1;
        chk("wrap_preset", retire_count, 32'hFFFF_FFFF);
        alu(5'd0, 32'h0);
        step();
        idle();
        #1;
        chk("wrap_retire", retire_count, 32'h0);
        step();
        step();

        chk("rf_q_drained", rf_q.size(), 0);
        chk("redir_q_drained", redir_q.size(), 0);
        chk("bp_q_drained", bp_q.size(), 0);
        chk("sb_q_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
